posit_pack_pipe: RTL and testbench
==================================

# posit_pack_pipe

Pipelined posit encoder. Takes the unpacked result fields from the add/subtract datapath (sign, regime k, exponent, normalised mantissa, inf/zero flags) and packs them into an N-bit posit word. Packing includes regime run-length encoding, round-to-nearest-even, saturation and the final two's-complement. Sits at the output of the arithmetic unit and applies valid/ready backpressure upstream.

## Interface
- N, 32, posit word width
- ES, 4, exponent field width
- RS, $clog2(N), regime index width; k is RS+1 bits signed
- clk  input  1  clock; all state changes on its rising edge
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  input fields valid this cycle
- in_ready  output  1  block accepts input this cycle
- sign  input  1  result sign (1 = negative)
- k  input  RS+1  signed regime value
- exponent  input  ES  unsigned exponent field
- mantissa  input  N  normalised mantissa; bit N-1 is the hidden 1; bits N-2:0 are the fraction
- inf  input  1  result is NaR
- zero  input  1  result is zero
- out_valid  output  1  out_posit valid
- out_ready  input  1  downstream accepts out_posit
- out_posit  output  N  packed posit

## Operation
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stage 1: register the fields.
  - Clamp: k >= N-2 → maxpos flag; k <= -(N-1) → minpos flag.
  - Regime run length: m = k+1 for k >= 0, m = -k for k < 0. Run bit r = (k >= 0).
- Stage 2: assemble the (N-1)-bit body after the sign, MSB first:
  - m copies of r;
  - terminator ~r, omitted when m = N-1;
  - ES exponent bits;
  - mantissa[N-2:0].
  - Truncate to N-1 bits. guard = first dropped bit; sticky = OR of all remaining dropped bits; round up iff guard & (sticky | body LSB).
  - Rounding never changes maxpos, because the clamp takes precedence.
  - A nonzero input whose body rounds to 0 becomes 1 (minpos); posits never round to zero or NaR.
- Stage 3: word = {1'b0, body}; if sign, word = -word.
  - Special-case priority: inf → {1'b1, (N-1) zeros}; otherwise zero → all zeros; otherwise maxpos → magnitude {0, (N-1) ones}; otherwise minpos → magnitude 1.
  - The sign is applied to the maxpos and minpos magnitudes.
- Intermediate widths: assembly vector at least 2N+ES bits, so that no shift loses sticky bits.

## Timing
- Latency: 3 cycles from input transfer to out_valid, when out_ready stays high. Throughput: 1 per cycle.
- Global pipeline enable: en = ~out_valid | out_ready. in_ready = en, combinational from out_ready and out_valid only.
- When en = 0, all three stages hold. Bubbles do not collapse.
- out_posit and out_valid are stable while out_valid & ~out_ready.
- Simultaneous input and output transfer in the same cycle is allowed; there is no loss and no duplication.
- Reset: stage valid bits and out_valid go to 0; out_posit and all stage data go to 0; in_ready is 1 in the first cycle after reset.
- Asserting rst_n low mid-stream discards all in-flight results; no partial output is produced.
- The inf, zero, maxpos and minpos paths have the same 3-cycle latency as normal values.

## Structure
- Shared package posit_pkg holds:
  - derived constants RS, MAXPOS_K = N-2, MINPOS_K = -(N-1);
  - the NaR pattern;
  - a struct typedef for the unpacked fields {sign, k, exponent, mantissa, inf, zero}, shared with the add/subtract unit.
- One sub-module, posit_round_rne: a combinational block that takes the assembled vector and produces {body, guard, sticky, rounded body}. It is instantiated in stage 2.

## Test plan
Parameters for every scenario: N=8, ES=1.
- sign=0, k=0, exponent=0, mantissa=0x80 → out_posit=0x40 three cycles after the transfer; same fields with sign=1 → 0xC0.
- k=-1, exponent=1, mantissa=0xC0 → 0x38.
- Rounding with k=0, exponent=0:
  - mantissa=0x86 (guard=1, sticky=1) → 0x41;
  - mantissa=0x84 (tie, LSB=0) → 0x40;
  - mantissa=0x8C (tie, LSB=1) → 0x42.
- Saturation: k=7 → 0x7F; k=-8 → 0x01; k=-8 with sign=1 → 0xFF.
- Special cases: inf=1 with any other fields → 0x80; zero=1 → 0x00; inf=1 together with zero=1 → 0x80.
- Backpressure and reset:
  - Stream 5 back-to-back inputs and hold out_ready low for 4 cycles → in_ready drops once the pipeline is full, out_posit stays stable, and all 5 results come out in order with none lost or duplicated.
  - Pull rst_n low for 1 cycle mid-stream → out_valid=0 in the next cycle and no stale result appears afterwards.

Source files
------------

// File: rtl/posit_pkg.sv
// posit_pkg: shared posit constants and the unpacked-field record exchanged
// between the add/subtract datapath and the packer.
package posit_pkg;
    localparam int POSIT_N  = 32;
    localparam int POSIT_ES = 4;
    localparam int RS       = $clog2(POSIT_N);
    localparam int MAXPOS_K = POSIT_N - 2;
    localparam int MINPOS_K = -(POSIT_N - 1);
    localparam logic [POSIT_N-1:0] NAR = {1'b1, {(POSIT_N-1){1'b0}}};

    typedef struct packed {
        logic                     sign;
        logic signed [RS:0]       k;
        logic [POSIT_ES-1:0]      exponent;
        logic [POSIT_N-1:0]       mantissa;
        logic                     inf;
        logic                     zero;
    } posit_fields_t;
endpackage

// File: rtl/posit_round_rne.sv
// posit_round_rne: truncates the assembled regime/exponent/fraction vector to
// the N-1 bit body and rounds it to nearest, ties to even.
module posit_round_rne #(
    parameter int N  = 32,
    parameter int ES = 4,
    parameter int W  = 2 * N + ES
) (
    input  logic [W-1:0] vec,
    output logic [N-2:0] body,
    output logic         guard,
    output logic         sticky,
    output logic [N-2:0] rounded
);
    always_comb begin
        body    = vec[W-1 -: N-1];
        guard   = vec[W-N];
        sticky  = |vec[W-N-1:0];
        rounded = body + (N-1)'(guard & (sticky | body[0]));
    end
endmodule

// File: rtl/posit_pack_pipe.sv
// posit_pack_pipe: three-stage posit encoder (field capture, regime assembly
// with rounding, sign application) under a single stall-everything enable.
module posit_pack_pipe #(
    parameter int N  = posit_pkg::POSIT_N,
    parameter int ES = posit_pkg::POSIT_ES,
    parameter int RS = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               sign,
    input  logic signed [RS:0] k,
    input  logic [ES-1:0]      exponent,
    input  logic [N-1:0]       mantissa,
    input  logic               inf,
    input  logic               zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N-1:0]       out_posit
);
    localparam int W = 2 * N + ES;
    localparam logic signed [RS:0] K_MAX  = (RS+1)'(N - 2);
    localparam logic signed [RS:0] K_MIN  = (RS+1)'(1 - N);
    localparam logic [RS:0]        M_FULL = (RS+1)'(N - 1);

    logic en;
    logic v1, s1, inf1, z1, max1, min1, r1;
    logic [RS:0] m1;
    logic [ES-1:0] e1;
    logic [N-2:0] f1;
    logic v2, s2, inf2, z2;
    logic [N-2:0] mag2;
    logic signed [W-1:0] pre, asm;
    logic [N-2:0] body, rounded;
    logic guard, sticky, to_zero;
    logic hidden_unused;

    assign en = ~out_valid | out_ready;
    assign in_ready = en;
    assign hidden_unused = mantissa[N-1];

    // Regime is built by sign-extending the run bit: shift {r,~r,...} right by m-1.
    always_comb begin
        pre = (m1 == M_FULL) ? $signed({r1, e1, f1, {N{1'b0}}})
                             : $signed({r1, ~r1, e1, f1, {(N-1){1'b0}}});
        asm = pre >>> (m1 - 1'b1);
        to_zero = (body == '0) & ~(guard & sticky);
    end

    posit_round_rne #(.N(N), .ES(ES), .W(W)) u_round (
        .vec(asm),
        .body(body),
        .guard(guard),
        .sticky(sticky),
        .rounded(rounded)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {v1, s1, inf1, z1, max1, min1, r1} <= '0;
            m1 <= '0;
            e1 <= '0;
            f1 <= '0;
            {v2, s2, inf2, z2} <= '0;
            mag2 <= '0;
            out_valid <= 1'b0;
            out_posit <= '0;
        end else if (en) begin
            v1 <= in_valid;
            s1 <= sign;
            inf1 <= inf;
            z1 <= zero;
            max1 <= k >= K_MAX;
            min1 <= k <= K_MIN;
            r1 <= ~k[RS];
            m1 <= k[RS] ? -k : k + 1'b1;
            e1 <= exponent;
            f1 <= mantissa[N-2:0];
            v2 <= v1;
            s2 <= s1;
            inf2 <= inf1;
            z2 <= z1;
            mag2 <= max1 ? '1 : (min1 | to_zero) ? (N-1)'(1) : rounded;
            out_valid <= v2;
            out_posit <= inf2 ? {1'b1, {(N-1){1'b0}}} :
                         z2   ? '0 :
                         s2   ? -{1'b0, mag2} : {1'b0, mag2};
        end
    end
endmodule

// File: tb/tb_posit_pack_pipe.sv
// tb_posit_pack_pipe: randomized and directed stimulus for the N=8, ES=1
// posit packer, checked against a bit-list model of the posit encoding rules.
module tb_posit_pack_pipe;
    localparam int N = 8;
    localparam int ES = 1;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic sign = 0, inf = 0, zero = 0;
    logic signed [3:0] k = 0;
    logic [0:0] exponent = 0;
    logic [7:0] mantissa = 8'h80;
    logic in_ready, out_valid;
    logic [7:0] out_posit;
    logic rnd_rdy = 0;

    typedef struct {logic [7:0] val; int cyc; int stl;} item_t;
    item_t q[$];
    int passed = 0, total = 0, cyc = 0, stalls = 0;

    posit_pack_pipe #(.N(N), .ES(ES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .k(k), .exponent(exponent), .mantissa(mantissa),
        .inf(inf), .zero(zero), .out_valid(out_valid), .out_ready(out_ready),
        .out_posit(out_posit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, req, req);
    endtask

    // Writes the body out bit by bit, then rounds on the dropped tail.
    function automatic logic [7:0] model(input logic s, input int kv, input int e,
                                         input int mv, input logic i_f, input logic z);
        int bits[$];
        int m, r, body, g, st, mag;
        if (i_f) return 8'h80;
        if (z) return 8'h00;
        if (kv >= N - 2) mag = 127;
        else if (kv <= -(N - 1)) mag = 1;
        else begin
            r = (kv >= 0) ? 1 : 0;
            m = r ? kv + 1 : -kv;
            repeat (m) bits.push_back(r);
            if (m != N - 1) bits.push_back(1 - r);
            for (int i = ES - 1; i >= 0; i--) bits.push_back((e >> i) & 1);
            for (int i = N - 2; i >= 0; i--) bits.push_back((mv >> i) & 1);
            while (bits.size() < N + 1) bits.push_back(0);
            body = 0;
            for (int i = 0; i < N - 1; i++) body = body * 2 + bits[i];
            g = bits[N-1];
            st = 0;
            for (int i = N; i < bits.size(); i++) st = st | bits[i];
            if (g != 0 && (st != 0 || body % 2 == 1)) body++;
            if (body == 0) body = 1;
            mag = body;
        end
        return s ? 8'(256 - mag) : 8'(mag);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) q.delete();
        else begin
            chk("in_ready_vs_en", int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out_valid", 1, 0);
                else begin
                    chk("out_posit", int'(out_posit), int'(q[0].val));
                    if (out_ready) begin
                        chk("latency", cyc - q[0].cyc, 3 + stalls - q[0].stl);
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready)
                q.push_back('{model(sign, int'(k), int'(exponent), int'(mantissa), inf, zero), cyc, stalls});
            if (out_valid && !out_ready) stalls++;
        end
        cyc++;
    end

    always @(posedge clk) if (rnd_rdy) begin
        #1 out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic s, input int kv, input int e, input int mv,
                        input logic i_f, input logic z);
        bit ok = 0;
        sign = s; k = 4'(kv); exponent = 1'(e); mantissa = 8'(mv);
        inf = i_f; zero = z; in_valid = 1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        if (!ok) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        chk("model_one", model(0, 0, 0, 'h80, 0, 0), 'h40);
        chk("model_neg_one", model(1, 0, 0, 'h80, 0, 0), 'hC0);
        chk("model_k_m1", model(0, -1, 1, 'hC0, 0, 0), 'h38);
        chk("model_rnd_up", model(0, 0, 0, 'h86, 0, 0), 'h41);
        chk("model_tie_even", model(0, 0, 0, 'h84, 0, 0), 'h40);
        chk("model_tie_odd", model(0, 0, 0, 'h8C, 0, 0), 'h42);
        chk("model_maxpos", model(0, 7, 0, 'h80, 0, 0), 'h7F);
        chk("model_minpos", model(0, -8, 0, 'h80, 0, 0), 'h01);
        chk("model_neg_minpos", model(1, -8, 0, 'h80, 0, 0), 'hFF);
        chk("model_nar", model(0, 3, 1, 'hA5, 1, 0), 'h80);
        chk("model_zero", model(1, 3, 1, 'hA5, 0, 1), 'h00);
        chk("model_nar_zero", model(0, 0, 0, 'h80, 1, 1), 'h80);

        idle(2);
        rst_n = 1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_posit", int'(out_posit), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        send(0, 0, 0, 'h80, 0, 0);
        idle(4);
        send(1, 0, 0, 'h80, 0, 0);
        send(0, -1, 1, 'hC0, 0, 0);
        send(0, 0, 0, 'h86, 0, 0);
        send(0, 0, 0, 'h84, 0, 0);
        send(0, 0, 0, 'h8C, 0, 0);
        send(0, 7, 0, 'h80, 0, 0);
        send(0, -8, 0, 'h80, 0, 0);
        send(1, -8, 0, 'h80, 0, 0);
        send(0, 5, 1, 'hF3, 1, 0);
        send(1, 2, 0, 'h9A, 0, 1);
        send(0, 0, 0, 'h80, 1, 1);
        send(1, 6, 1, 'hFF, 0, 0);
        send(1, -7, 0, 'h80, 0, 0);
        idle(6);

        out_ready = 0;
        fork
            begin
                send(0, 1, 0, 'h80, 0, 0);
                send(1, 2, 1, 'hC4, 0, 0);
                send(0, -2, 0, 'hB7, 0, 0);
                send(0, 3, 1, 'h8F, 0, 0);
                send(1, -3, 1, 'hE1, 0, 0);
            end
            begin
                repeat (4) @(negedge clk);
                chk("full_in_ready_low", int'(in_ready), 0);
                chk("full_out_valid", int'(out_valid), 1);
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        idle(6);
        chk("bp_drained", q.size(), 0);

        send(0, 1, 1, 'hA0, 0, 0);
        send(1, -2, 0, 'hD0, 0, 0);
        send(0, 2, 1, 'h81, 0, 0);
        send(0, -1, 0, 'hFE, 0, 0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        idle(6);

        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            send(1'($urandom), $signed(4'($urandom_range(0, 15))), int'($urandom_range(0, 1)),
                 int'({1'b1, 7'($urandom)}), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        rnd_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1;
        idle(10);
        chk("final_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
